// File: rtl/one_run_scheduler_pkg.sv
// Shared types for one_run_scheduler: FSM state and counter-owner encodings.
package one_run_scheduler_pkg;

  localparam int unsigned DEF_CNT_W       = 8;
  localparam int unsigned DEF_PER_W       = 30;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  function automatic owner_e other_side(input owner_e o);
    return (o == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/one_run_scheduler_if.sv
// Request/limit/status bundle of one_run_scheduler; abort/aborted exist only
// when ONE_RUN_ABORT_EN is defined.
interface one_run_scheduler_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PER_W = 30
);
  logic             req_a;
  logic             req_b;
  logic [CNT_W-1:0] limit_a;
  logic [CNT_W-1:0] limit_b;
  logic [PER_W-1:0] period;
  logic             busy;
  logic             grant_a;
  logic             grant_b;
  logic             tick;
  logic [CNT_W-1:0] count;
  logic             done_a;
  logic             done_b;
`ifdef ONE_RUN_ABORT_EN
  logic             abort;
  logic             aborted;
`endif

  modport master (
    output req_a, req_b, limit_a, limit_b, period,
`ifdef ONE_RUN_ABORT_EN
    output abort,
    input  aborted,
`endif
    input  busy, grant_a, grant_b, tick, count, done_a, done_b
  );

  modport slave (
    input  req_a, req_b, limit_a, limit_b, period,
`ifdef ONE_RUN_ABORT_EN
    input  abort,
    output aborted,
`endif
    output busy, grant_a, grant_b, tick, count, done_a, done_b
  );
endinterface

// File: rtl/one_run_scheduler_req_edge_sync.sv
// Synchronizes an asynchronous request level and emits a one-cycle pulse on
// each rising edge of the synchronized level.
module req_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
      last_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~last_q;

endmodule

// File: rtl/one_run_scheduler.sv
// Round-robin sharing of one single-shot run counter between requesters A and B.
// Define ONE_RUN_ABORT_EN to add the abort input and aborted flag.
module one_run_scheduler
  import one_run_scheduler_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned PER_W       = DEF_PER_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input logic                qzt_clk,
  input logic                rst_n,
  one_run_scheduler_if.slave bus
);

  logic rise_a, rise_b;

  req_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk_i  (qzt_clk),
    .rst_ni (rst_n),
    .req_i  (bus.req_a),
    .rise_o (rise_a)
  );

  req_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk_i  (qzt_clk),
    .rst_ni (rst_n),
    .req_i  (bus.req_b),
    .rise_o (rise_b)
  );

  state_e           state_q, state_d;
  owner_e           owner_q, owner_d;
  owner_e           rr_q, rr_d;
  logic             pend_a_q, pend_a_d;
  logic             pend_b_q, pend_b_d;
  logic [CNT_W-1:0] lim_q, lim_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] pre_q, pre_d;
  logic             gnt_a, gnt_b, tick;
  logic             start;
  logic             abort_in;
  logic             aborted_q, aborted_d;

`ifdef ONE_RUN_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    lim_d     = lim_q;
    per_d     = per_q;
    pre_d     = pre_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    tick      = 1'b0;
    start     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // The RR pointer only moves on a genuine tie; a lone request leaves it alone.
        if (pend_a_q && pend_b_q) begin
          start   = 1'b1;
          owner_d = rr_q;
          rr_d    = other_side(rr_q);
        end else if (pend_a_q) begin
          start   = 1'b1;
          owner_d = OWN_A;
        end else if (pend_b_q) begin
          start   = 1'b1;
          owner_d = OWN_B;
        end
        if (start) begin
          gnt_a     = (owner_d == OWN_A);
          gnt_b     = (owner_d == OWN_B);
          lim_d     = (owner_d == OWN_A) ? bus.limit_a : bus.limit_b;
          per_d     = (bus.period == '0) ? PER_W'(1) : bus.period;
          aborted_d = 1'b0;
          state_d   = S_ARM;
        end
      end
      S_ARM: begin
        cnt_d = '0;
        pre_d = '0;
        if (abort_in) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (lim_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (abort_in) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (pre_q == per_q - 1'b1) begin
          tick  = 1'b1;
          pre_d = '0;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q + 1'b1 == lim_q) state_d = S_DONE;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A fresh edge wins over the grant-clear so an edge during the owner's run re-queues it.
    pend_a_d = rise_a | (pend_a_q & ~gnt_a);
    pend_b_d = rise_b | (pend_b_q & ~gnt_b);
  end

  always_ff @(posedge qzt_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_A;
      rr_q      <= OWN_A;
      pend_a_q  <= 1'b0;
      pend_b_q  <= 1'b0;
      lim_q     <= '0;
      per_q     <= '0;
      pre_q     <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_q      <= rr_d;
      pend_a_q  <= pend_a_d;
      pend_b_q  <= pend_b_d;
      lim_q     <= lim_d;
      per_q     <= per_d;
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  logic active;
  assign active = (state_q == S_ARM) || (state_q == S_RUN);

  assign bus.busy    = active;
  assign bus.grant_a = gnt_a | (active && owner_q == OWN_A);
  assign bus.grant_b = gnt_b | (active && owner_q == OWN_B);
  assign bus.tick    = tick;
  assign bus.count   = cnt_q;
  assign bus.done_a  = (state_q == S_DONE) && (owner_q == OWN_A);
  assign bus.done_b  = (state_q == S_DONE) && (owner_q == OWN_B);
`ifdef ONE_RUN_ABORT_EN
  assign bus.aborted = (state_q == S_DONE) && aborted_q;
`endif

endmodule

// File: tb/tb_one_run_scheduler.sv
// Directed, table-driven bench for one_run_scheduler (abort sequence under ONE_RUN_ABORT_EN).
module tb_one_run_scheduler;
  import one_run_scheduler_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PER_W = 30;

  logic qzt_clk = 1'b0;
  logic rst_n   = 1'b0;

  one_run_scheduler_if #(.CNT_W(CNT_W), .PER_W(PER_W)) bus ();

  one_run_scheduler #(.CNT_W(CNT_W), .PER_W(PER_W), .SYNC_STAGES(2)) dut (
    .qzt_clk (qzt_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #20 qzt_clk = ~qzt_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic pick(input int w);
    case (w)
      0:       return bus.grant_a;
      1:       return bus.grant_b;
      2:       return bus.done_a;
      3:       return bus.done_b;
      default: return bus.grant_a | bus.grant_b;
    endcase
  endfunction

  task automatic wait_for(input int w, input int unsigned bound, output int unsigned n);
    n = 0;
    do begin
      @(negedge qzt_clk);
      n++;
    end while (!pick(w) && n < bound);
  endtask

  typedef struct {
    bit          side;
    int unsigned lim;
    int unsigned per;
    int unsigned lat;
    int unsigned nticks;
    int unsigned fin;
  } vec_t;

  vec_t vecs[6];

  task automatic run_one(input bit side, input int unsigned lim, input int unsigned per,
                         input int unsigned lat, input int unsigned nticks,
                         input int unsigned fin, input string tag);
    int unsigned k, idx, tk, done_at;
    bit          track_ok, dseen;
    logic [CNT_W-1:0] lim_v;
    lim_v = CNT_W'(lim);
    @(negedge qzt_clk);
    bus.period = PER_W'(per);
    if (side) begin bus.limit_b = lim_v; bus.req_b = 1'b1; end
    else      begin bus.limit_a = lim_v; bus.req_a = 1'b1; end
    wait_for(side ? 1 : 0, 20, k);
    check({tag, "_grant_lat"}, int'(k), 3);
    bus.req_a = 1'b0;
    bus.req_b = 1'b0;
    idx = 0; tk = 0; done_at = 0; track_ok = 1'b1; dseen = 1'b0;
    while (!dseen && idx < lat + 50) begin
      @(negedge qzt_clk);
      idx++;
      if (idx == 1) begin
        if (side) bus.limit_b = lim_v ^ 8'hA5;
        else      bus.limit_a = lim_v ^ 8'hA5;
      end
      if (idx >= 2 && int'(bus.count) != int'(tk)) track_ok = 1'b0;
      if (pick(side ? 3 : 2)) begin
        dseen   = 1'b1;
        done_at = idx;
      end else if (bus.tick) begin
        tk++;
      end
    end
    check({tag, "_done_lat"}, int'(done_at), int'(lat));
    check({tag, "_ticks"}, int'(tk), int'(nticks));
    check({tag, "_count_at_done"}, int'(bus.count), int'(fin));
    check({tag, "_count_track"}, int'(track_ok), 1);
    @(negedge qzt_clk);
    check({tag, "_after_flags"},
          int'({bus.busy, bus.grant_a, bus.grant_b, bus.done_a, bus.done_b}), 0);
    check({tag, "_count_hold"}, int'(bus.count), int'(fin));
  endtask

  initial begin
    int unsigned n, n2;
    bit          any;

    vecs[0] = '{1'b0,   5, 1,   7,   5,   5};
    vecs[1] = '{1'b1,   0, 3,   2,   0,   0};
    vecs[2] = '{1'b0,   3, 0,   5,   3,   3};
    vecs[3] = '{1'b1,   2, 3,   8,   2,   2};
    vecs[4] = '{1'b0, 255, 1, 257, 255, 255};
    vecs[5] = '{1'b1,   1, 4,   6,   1,   1};

    bus.req_a = 1'b0; bus.req_b = 1'b0;
    bus.limit_a = '0; bus.limit_b = '0; bus.period = '0;
`ifdef ONE_RUN_ABORT_EN
    bus.abort = 1'b0;
`endif
    #10;
    check("reset_outputs",
          int'({bus.busy, bus.grant_a, bus.grant_b, bus.tick, bus.done_a, bus.done_b, bus.count}), 0);
    @(negedge qzt_clk);
    rst_n = 1'b1;
    repeat (2) @(negedge qzt_clk);

    for (int i = 0; i < 6; i++)
      run_one(vecs[i].side, vecs[i].lim, vecs[i].per, vecs[i].lat,
              vecs[i].nticks, vecs[i].fin, $sformatf("vec%0d", i));

    // Tie: A first (pointer at reset), B right after A's DONE, next tie goes to B.
    @(negedge qzt_clk);
    bus.limit_a = 8'd3; bus.limit_b = 8'd4; bus.period = 30'd2;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    wait_for(4, 20, n);
    check("tie1_winner_a", int'({bus.grant_a, bus.grant_b}), 2);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    wait_for(2, 40, n);
    check("tie1_done_a_lat", int'(n), 8);
    check("tie1_count_a", int'(bus.count), 3);
    @(negedge qzt_clk);
    check("tie1_grant_b_next", int'({bus.grant_a, bus.grant_b}), 1);
    wait_for(3, 40, n);
    check("tie1_done_b_lat", int'(n), 10);
    check("tie1_count_b", int'(bus.count), 4);
    repeat (3) @(negedge qzt_clk);
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    wait_for(4, 20, n);
    check("tie2_winner_b", int'({bus.grant_a, bus.grant_b}), 1);
    bus.req_a = 1'b0; bus.req_b = 1'b0;
    wait_for(3, 40, n);
    wait_for(2, 40, n2);
    check("tie2_done_a_after_b", int'(bus.done_a), 1);
    repeat (2) @(negedge qzt_clk);

    // Reset mid-run with B pending: everything clears, no done, no stale grant.
    @(negedge qzt_clk);
    bus.limit_a = 8'd5; bus.period = 30'd1; bus.req_a = 1'b1;
    wait_for(0, 20, n);
    bus.req_a = 1'b0; bus.req_b = 1'b1;
    repeat (3) @(negedge qzt_clk);
    bus.req_b = 1'b0;
    @(negedge qzt_clk);
    check("rst_pre_count", int'(bus.count), 2);
    #5 rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          int'({bus.busy, bus.grant_a, bus.grant_b, bus.tick, bus.done_a, bus.done_b, bus.count}), 0);
    @(negedge qzt_clk);
    rst_n = 1'b1;
    any = 1'b0;
    repeat (8) begin
      @(negedge qzt_clk);
      if (bus.busy || bus.grant_a || bus.grant_b || bus.done_a || bus.done_b) any = 1'b1;
    end
    check("rst_pending_cleared", int'(any), 0);
    run_one(1'b0, 2, 1, 4, 2, 2, "post_rst");

`ifdef ONE_RUN_ABORT_EN
    @(negedge qzt_clk);
    bus.limit_a = 8'd10; bus.period = 30'd1; bus.req_a = 1'b1;
    wait_for(0, 20, n);
    bus.req_a = 1'b0;
    repeat (5) @(negedge qzt_clk);
    check("abort_pre_count", int'(bus.count), 3);
    bus.abort = 1'b1;
    @(negedge qzt_clk);
    bus.abort = 1'b0;
    check("abort_done_flags", int'({bus.done_a, bus.aborted}), 3);
    check("abort_count_hold", int'(bus.count), 3);
    @(negedge qzt_clk);
    check("abort_after", int'({bus.done_a, bus.aborted, bus.busy}), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
